// File: rtl/zstr_drn.sv
// Z-stream drain: paces z_rdy from a queue of programmed delays and queues each captured word
// together with the number of cycles z_vld waited. Define ZSTR_DRN_CHECK_EN for the err checker.
module zstr_drn #(
  parameter int unsigned BW = 1,
  parameter int unsigned QL = 4,
  parameter int unsigned QW = $clog2(QL),
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          z_vld,
  input  logic [BW-1:0] z_bus,
  output logic          z_rdy,
  input  logic          t_vld,
  input  logic [TW-1:0] t_dly,
  output logic          t_rdy,
  output logic          d_vld,
  output logic [BW-1:0] d_bus,
  output logic [TW-1:0] d_tmg,
  input  logic          d_rdy,
  output logic          err
);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned DW = TW + BW;
  localparam logic [CW-1:0] QLen = CW'(QL);
  localparam logic [QW-1:0] PtrMax = QW'(QL - 1);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d, z_tmg_q, z_tmg_d;
  logic [TW-1:0] t_mem_q [QL];
  logic [DW-1:0] d_mem_q [QL];
  logic [DW-1:0] d_head;
  logic [QW-1:0] t_wp_q, t_wp_d, t_rp_q, t_rp_d;
  logic [QW-1:0] d_wp_q, d_wp_d, d_rp_q, d_rp_d;
  logic [CW-1:0] t_cnt_q, t_cnt_d, d_cnt_q, d_cnt_d;
  logic          t_push, t_pop, d_push, d_pop, z_trn, sp;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == PtrMax) ? '0 : p + QW'(1);
  endfunction

  always_comb begin
    t_rdy   = t_cnt_q < QLen;
    d_vld   = d_cnt_q != '0;
    z_rdy   = state_q == StReady;
    z_trn   = z_vld & z_rdy;
    t_push  = t_vld & t_rdy;
    d_pop   = d_vld & d_rdy;
    d_push  = z_trn;
    d_cnt_d = d_cnt_q + CW'(d_push) - CW'(d_pop);
    // A delay is only consumed when the data queue is guaranteed a free slot for its word.
    sp      = d_cnt_d < QLen;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_pop   = 1'b0;
    unique case (state_q)
      StIdle: t_pop = (t_cnt_q != '0) && sp;
      StWait: begin
        cnt_d = cnt_q - TW'(1);
        if (cnt_q == TW'(1)) state_d = StReady;
      end
      StReady: begin
        if (z_trn) begin
          t_pop   = (t_cnt_q != '0) && sp;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (t_pop) begin
      if (t_mem_q[t_rp_q] == '0) begin
        state_d = StReady;
      end else begin
        state_d = StWait;
        cnt_d   = t_mem_q[t_rp_q];
      end
    end
  end

  always_comb begin
    t_wp_d  = t_push ? ptr_inc(t_wp_q) : t_wp_q;
    t_rp_d  = t_pop  ? ptr_inc(t_rp_q) : t_rp_q;
    d_wp_d  = d_push ? ptr_inc(d_wp_q) : d_wp_q;
    d_rp_d  = d_pop  ? ptr_inc(d_rp_q) : d_rp_q;
    t_cnt_d = t_cnt_q + CW'(t_push) - CW'(t_pop);
    z_tmg_d = z_tmg_q;
    if (z_trn) begin
      z_tmg_d = '0;
    end else if (z_vld && (z_tmg_q != '1)) begin
      z_tmg_d = z_tmg_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      z_tmg_q <= '0;
      t_wp_q  <= '0;
      t_rp_q  <= '0;
      d_wp_q  <= '0;
      d_rp_q  <= '0;
      t_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_tmg_q <= z_tmg_d;
      t_wp_q  <= t_wp_d;
      t_rp_q  <= t_rp_d;
      d_wp_q  <= d_wp_d;
      d_rp_q  <= d_rp_d;
      t_cnt_q <= t_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  // Storage needs no reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (t_push) t_mem_q[t_wp_q] <= t_dly;
    if (d_push) d_mem_q[d_wp_q] <= {z_tmg_q, z_bus};
  end

  assign d_head = d_mem_q[d_rp_q];
  assign d_bus  = d_head[BW-1:0];
  assign d_tmg  = d_head[DW-1:BW];

`ifdef ZSTR_DRN_CHECK_EN
  logic          err_q, err_d, hold_q, hold_d, x_bad;
  logic [BW-1:0] bus_q, bus_d;

  always_comb begin
    hold_d = z_vld & ~z_rdy;
    bus_d  = z_bus;
    x_bad  = $isunknown(z_vld) || (z_vld && $isunknown(z_bus));
    // A held word must stay valid and stable until it is accepted.
    err_d  = err_q | (hold_q & ~z_vld) | (hold_q & (z_bus != bus_q)) | x_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q  <= 1'b0;
      hold_q <= 1'b0;
      bus_q  <= '0;
    end else begin
      err_q  <= err_d;
      hold_q <= hold_d;
      bus_q  <= bus_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_zstr_drn.sv
// Directed bench for zstr_drn: stimulus pushes expected (word, wait) pairs into a scoreboard
// queue; a negedge monitor compares them as the DUT pops its data queue.
module tb_zstr_drn;
  localparam int unsigned BW = 8;
  localparam int unsigned QL = 4;
  localparam int unsigned TW = 16;
`ifdef ZSTR_DRN_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic          clk, rst;
  logic          z_vld, z_rdy, t_vld, t_rdy, d_vld, d_rdy, err;
  logic [BW-1:0] z_bus, d_bus;
  logic [TW-1:0] t_dly, d_tmg;

  int checks = 0;
  int errors = 0;
  int n_trn  = 0;
  int base, k;
  logic rdy_s;
  logic [BW-1:0]    src_q[$];
  logic [TW+BW-1:0] exp_q[$];

  zstr_drn #(.BW(BW), .QL(QL), .TW(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .z_vld (z_vld),
    .z_bus (z_bus),
    .z_rdy (z_rdy),
    .t_vld (t_vld),
    .t_dly (t_dly),
    .t_rdy (t_rdy),
    .d_vld (d_vld),
    .d_bus (d_bus),
    .d_tmg (d_tmg),
    .d_rdy (d_rdy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Scoreboard monitor: every data-queue pop is compared against the oldest expectation.
  always @(negedge clk) begin
    logic [TW+BW-1:0] e;
    if (rst) begin
      if (z_vld && z_rdy) n_trn++;
      if (d_vld && d_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_pop_unexpected: got bus %0h tmg %0d expected no entry", d_bus, d_tmg);
        end else begin
          e = exp_q.pop_front();
          chk("d_bus", {24'd0, d_bus}, {24'd0, e[BW-1:0]});
          chk("d_tmg", {16'd0, d_tmg}, {16'd0, e[TW+BW-1:BW]});
        end
      end
    end
  end

  // One clock: sample at negedge, advance the source after any transfer, return at posedge+1.
  task automatic cyc();
    logic trn;
    @(negedge clk);
    trn   = z_vld && z_rdy && rst;
    rdy_s = z_rdy;
    @(posedge clk);
    #1;
    if (trn) begin
      void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        z_bus = src_q[0];
      end else begin
        z_vld = 1'b0;
      end
    end
  endtask

  task automatic src_push(input logic [BW-1:0] w);
    src_q.push_back(w);
    if (!z_vld) begin
      z_vld = 1'b1;
      z_bus = w;
    end
  endtask

  task automatic exp_push(input logic [BW-1:0] b, input logic [TW-1:0] t);
    exp_q.push_back({t, b});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; z_vld = 1'b0; z_bus = '0; t_vld = 1'b0; t_dly = '0; d_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_z_rdy", z_rdy, 1'b0);
    chk1("rst_t_rdy", t_rdy, 1'b1);
    chk1("rst_d_vld", d_vld, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b1;

    // Back-to-back zero delays: three consecutive transfers, no waiting.
    d_rdy = 1'b1;
    t_vld = 1'b1; t_dly = '0;
    repeat (3) cyc();
    t_vld = 1'b0;
    repeat (2) cyc();
    base = n_trn;
    src_push(8'h01); src_push(8'h02); src_push(8'h03);
    exp_push(8'h01, 0); exp_push(8'h02, 0); exp_push(8'h03, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("t1_rdy_high", rdy_s, 1'b1);
    end
    chk("t1_ntrn", n_trn - base, 3);
    cyc();
    chk1("t1_rdy_low", rdy_s, 1'b0);
    repeat (3) cyc();
    chk("t1_drain", src_q.size() + exp_q.size(), 0);

    // Delay 3 with the source valid from the pop cycle.
    t_vld = 1'b1; t_dly = 16'd3;
    cyc();
    t_vld = 1'b0;
    src_push(8'h44);
    exp_push(8'h44, 4);
    k = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rdy_s) begin
        k = i;
        break;
      end
    end
    chk("t2_latency", k, 4);
    repeat (3) cyc();
    chk("t2_drain", exp_q.size(), 0);

    // Source waits on an empty timing queue, then a zero delay arrives.
    src_push(8'h5a);
    exp_push(8'h5a, 11);
    repeat (9) cyc();
    t_vld = 1'b1; t_dly = '0;
    cyc();
    t_vld = 1'b0;
    chk1("t4_rdy_push", rdy_s, 1'b0);
    cyc();
    chk1("t4_rdy_pop", rdy_s, 1'b0);
    cyc();
    chk1("t4_rdy_xfer", rdy_s, 1'b1);
    repeat (3) cyc();
    chk("t4_drain", exp_q.size(), 0);

    // Backpressure: full data queue stops after exactly four transfers.
    d_rdy = 1'b0;
    base  = n_trn;
    for (int i = 0; i < 6; i++) src_push(BW'(8'h10 + i));
    exp_push(8'h10, 2); exp_push(8'h11, 0); exp_push(8'h12, 0);
    exp_push(8'h13, 0); exp_push(8'h14, 7); exp_push(8'h15, 3);
    t_vld = 1'b1; t_dly = '0;
    repeat (6) cyc();
    t_vld = 1'b0;
    chk("t3_ntrn_full", n_trn - base, 4);
    chk1("t3_t_rdy", t_rdy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk1("t3_rdy_blocked", rdy_s, 1'b0);
    end
    d_rdy = 1'b1;
    cyc();
    d_rdy = 1'b0;
    repeat (3) cyc();
    chk("t3_ntrn_pulse", n_trn - base, 5);
    d_rdy = 1'b1;
    repeat (8) cyc();
    chk("t3_ntrn_end", n_trn - base, 6);
    chk("t3_drain", exp_q.size(), 0);

    // Reset while waiting on delay 7 (count at 5) with two words queued.
    d_rdy = 1'b0;
    base  = n_trn;
    src_push(8'h61); src_push(8'h62);
    t_vld = 1'b1; t_dly = '0;
    repeat (2) cyc();
    t_dly = 16'd7;
    cyc();
    t_vld = 1'b0;
    repeat (3) cyc();
    chk("t5_ntrn", n_trn - base, 2);
    chk1("t5_d_vld_pre", d_vld, 1'b1);
    rst = 1'b0;
    cyc();
    chk1("t5_z_rdy", z_rdy, 1'b0);
    chk1("t5_d_vld", d_vld, 1'b0);
    chk1("t5_t_rdy", t_rdy, 1'b1);
    rst   = 1'b1;
    d_rdy = 1'b1;
    t_vld = 1'b1; t_dly = '0;
    cyc();
    t_vld = 1'b0;
    cyc();
    chk1("t5_rdy_pop", rdy_s, 1'b0);
    src_push(8'h77);
    exp_push(8'h77, 0);
    cyc();
    chk1("t5_rdy_fresh", rdy_s, 1'b1);
    repeat (3) cyc();
    chk("t5_drain", exp_q.size(), 0);

    // Bus changes while held: checker flags it and keeps the flag until reset.
    z_vld = 1'b1; z_bus = 8'h80;
    cyc();
    chk1("t6_err_before", err, 1'b0);
    z_bus = 8'h81;
    cyc();
    chk1("t6_err_set", err, ExpErr);
    repeat (3) cyc();
    chk1("t6_err_sticky", err, ExpErr);
    z_vld = 1'b0;
    rst   = 1'b0;
    cyc();
    rst   = 1'b1;
    chk1("t6_err_cleared", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
